// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: stall, halt/resume FSM, post-redirect flush counter, link strobe, alignment check.
// Optional exception/return path (SIIC/RTI with saved epc) enabled by defining PC_EXC_EN.
module pc_seq_unit #(
  parameter int unsigned          ADDR_W     = 16,
  parameter int unsigned          INSTR_W    = 16,
  parameter int unsigned          INC        = 2,
  parameter logic [ADDR_W-1:0]    RESET_PC   = '0,
  parameter int unsigned          FLUSH_CYC  = 2,
  parameter logic [ADDR_W-1:0]    EXC_VECTOR = ADDR_W'(16'h0002)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  input  logic [ADDR_W-1:0]  rs,
  input  logic [ADDR_W-1:0]  ext,
  input  logic               stall,
  input  logic               resume,
  output logic [ADDR_W-1:0]  instr_addr,
  output logic [ADDR_W-1:0]  pc_plus,
  output logic               link_we,
  output logic [ADDR_W-1:0]  link_addr,
  output logic               flush,
  output logic               halted,
  output logic               misalign,
  output logic [ADDR_W-1:0]  epc
);

  localparam int unsigned OP_W  = 5;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {RUN, HALTED} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                link_we_q, link_we_d;
  logic [ADDR_W-1:0]   link_addr_q, link_addr_d;
  logic                misalign_q, misalign_d;
  logic [OP_W-1:0]     opcode;
  logic                taken;
  logic                link;
  logic [ADDR_W-1:0]   target;
  logic                unused_instr_bits;

  assign opcode            = instr[INSTR_W-1 -: OP_W];
  assign unused_instr_bits = ^instr[INSTR_W-OP_W-1:0];
  assign pc_plus           = pc_q + ADDR_W'(INC);

`ifdef PC_EXC_EN
  logic [ADDR_W-1:0] epc_q, epc_d;
`endif

  // Next-state: flush drain, accepted-instruction decode, halt/resume
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    link_we_d   = 1'b0;
    link_addr_d = link_addr_q;
    misalign_d  = 1'b0;
    taken       = 1'b0;
    link        = 1'b0;
    target      = '0;
`ifdef PC_EXC_EN
    epc_d       = epc_q;
`endif
    case (state_q)
      RUN: begin
        if (cnt_q != '0) begin
          if (!stall) begin
            pc_d  = pc_plus;
            cnt_d = cnt_q - CNT_W'(1);
          end
        end else if (instr_valid && !stall) begin
          pc_d = pc_plus;
          casez (opcode)
            5'b00000: begin
              pc_d    = pc_q;
              state_d = HALTED;
            end
            5'b011??: begin
              target = pc_plus + ext;
              case (opcode[1:0])
                2'b00:   taken = (rs == '0);
                2'b01:   taken = (rs != '0);
                2'b10:   taken = rs[ADDR_W-1];
                default: taken = !rs[ADDR_W-1];
              endcase
            end
            5'b00100: begin
              target = pc_plus + ext;
              taken  = 1'b1;
            end
            5'b00110: begin
              target = pc_plus + ext;
              taken  = 1'b1;
              link   = 1'b1;
            end
            5'b00101: begin
              target = rs + ext;
              taken  = 1'b1;
            end
            5'b00111: begin
              target = rs + ext;
              taken  = 1'b1;
              link   = 1'b1;
            end
`ifdef PC_EXC_EN
            5'b00010: begin
              epc_d = pc_plus;
              pc_d  = EXC_VECTOR;
              cnt_d = CNT_W'(FLUSH_CYC);
            end
            5'b00011: begin
              pc_d  = epc_q;
              cnt_d = CNT_W'(FLUSH_CYC);
            end
`endif
            default: ;
          endcase
          // Taken targets are forced even; an odd computed target is reported once
          if (taken) begin
            pc_d       = {target[ADDR_W-1:1], 1'b0};
            misalign_d = target[0];
            cnt_d      = CNT_W'(FLUSH_CYC);
          end
          if (link) begin
            link_we_d   = 1'b1;
            link_addr_d = pc_plus;
          end
        end
      end
      HALTED: begin
        if (resume) begin
          pc_d    = pc_plus;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      cnt_q       <= '0;
      link_we_q   <= 1'b0;
      link_addr_q <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      link_we_q   <= link_we_d;
      link_addr_q <= link_addr_d;
      misalign_q  <= misalign_d;
    end
  end

`ifdef PC_EXC_EN
  always_ff @(posedge clk) begin
    if (rst) epc_q <= '0;
    else     epc_q <= epc_d;
  end
  assign epc = epc_q;
`else
  assign epc = '0;
`endif

  assign instr_addr = pc_q;
  assign link_we    = link_we_q;
  assign link_addr  = link_addr_q;
  assign misalign   = misalign_q;
  assign flush      = (cnt_q != '0);
  assign halted     = (state_q == HALTED);

endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed bench for pc_seq_unit: cycle-level behavioural model plus hand-computed literal checks.
module tb_pc_seq_unit;

  localparam int FLUSH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic [15:0] rs = '0;
  logic [15:0] ext = '0;
  logic        stall = 1'b0;
  logic        resume = 1'b0;
  logic [15:0] instr_addr, pc_plus, link_addr, epc;
  logic        link_we, flush, halted, misalign;

  pc_seq_unit dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .rs(rs), .ext(ext),
    .stall(stall), .resume(resume), .instr_addr(instr_addr), .pc_plus(pc_plus),
    .link_we(link_we), .link_addr(link_addr), .flush(flush), .halted(halted),
    .misalign(misalign), .epc(epc)
  );

  always #5 clk = ~clk;

  // Model state: what the outputs must show after the most recent edge
  logic [15:0] m_pc = '0, m_la = '0, m_epc = '0;
  bit          m_halted = 0, m_lwe = 0, m_mis = 0;
  int          m_fc = 0;
  int          errors = 0, checks = 0;
  bit          chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("instr_addr", 32'(instr_addr), 32'(m_pc));
      chk("pc_plus",    32'(pc_plus),    32'(16'(m_pc + 16'd2)));
      chk("link_we",    32'(link_we),    32'(m_lwe));
      chk("link_addr",  32'(link_addr),  32'(m_la));
      chk("flush",      32'(flush),      32'(m_fc != 0));
      chk("halted",     32'(halted),     32'(m_halted));
      chk("misalign",   32'(misalign),   32'(m_mis));
      chk("epc",        32'(epc),        32'(m_epc));
    end
  end

  // Apply one clock of the architectural rules to the model
  task automatic model_step();
    logic [4:0]  op;
    logic [15:0] seq, t;
    bit          jump, lnk;
    op = instr[15:11];
    seq = m_pc + 16'd2;
    jump = 0;
    lnk = 0;
    t = '0;
    if (rst) begin
      m_pc = '0; m_la = '0; m_epc = '0; m_halted = 0; m_lwe = 0; m_mis = 0; m_fc = 0;
      return;
    end
    m_lwe = 0;
    m_mis = 0;
    if (m_halted) begin
      if (resume) begin m_pc = seq; m_halted = 0; end
    end else if (m_fc > 0) begin
      if (!stall) begin m_pc = seq; m_fc = m_fc - 1; end
    end else if (instr_valid && !stall) begin
      m_pc = seq;
      if (op == 5'd0) begin
        m_pc = seq - 16'd2;
        m_halted = 1;
      end else if (op[4:2] == 3'b011) begin
        t = seq + ext;
        if (op[1:0] == 2'd0) jump = (rs == 0);
        if (op[1:0] == 2'd1) jump = (rs != 0);
        if (op[1:0] == 2'd2) jump = ($signed(rs) < 0);
        if (op[1:0] == 2'd3) jump = ($signed(rs) >= 0);
      end else if (op == 5'd4 || op == 5'd6) begin
        t = seq + ext; jump = 1; lnk = (op == 5'd6);
      end else if (op == 5'd5 || op == 5'd7) begin
        t = rs + ext; jump = 1; lnk = (op == 5'd7);
      end
`ifdef PC_EXC_EN
      else if (op == 5'd2) begin
        m_epc = seq; m_pc = 16'h0002; m_fc = FLUSH;
      end else if (op == 5'd3) begin
        m_pc = m_epc; m_fc = FLUSH;
      end
`endif
      if (jump) begin
        m_pc = t & 16'hFFFE;
        m_mis = t[0];
        m_fc = FLUSH;
      end
      if (lnk) begin
        m_lwe = 1;
        m_la = seq;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic op(input logic [4:0] opc, input logic [15:0] r, input logic [15:0] e);
    instr_valid = 1'b1;
    instr = {opc, 11'h000};
    rs = r;
    ext = e;
    tick();
  endtask

  task automatic idle(input int n);
    instr_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  localparam logic [4:0] NOP = 5'b11111, HALT = 5'b00000, BEQZ = 5'b01100, BNEZ = 5'b01101,
                         BLTZ = 5'b01110, BGEZ = 5'b01111, J = 5'b00100, JR = 5'b00101,
                         JAL = 5'b00110, JALR = 5'b00111, SIIC = 5'b00010, RTI = 5'b00011;

  initial begin
    @(negedge clk);
    #1;
    chk_en = 1;
    rst = 1'b1;
    idle(1);
    chk("lit_reset_pc", 32'(instr_addr), 32'h0);
    chk("lit_reset_flush", 32'(flush), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) op(NOP, 16'h0, 16'h0);
    chk("lit_nop_pc", 32'(instr_addr), 32'h8);
    for (int i = 0; i < 4; i++) op(NOP, 16'h0, 16'h0);

    op(BEQZ, 16'h0000, 16'h0006);
    chk("lit_beqz_pc", 32'(instr_addr), 32'h18);
    chk("lit_beqz_flush", 32'(flush), 32'h1);
    op(J, 16'h0, 16'h0100);
    op(J, 16'h0, 16'h0100);
    chk("lit_flush_done_pc", 32'(instr_addr), 32'h1C);

    op(NOP, 16'h0, 16'h0);
    op(NOP, 16'h0, 16'h0);
    op(JALR, 16'h0101, 16'h0000);
    chk("lit_jalr_pc", 32'(instr_addr), 32'h100);
    chk("lit_jalr_mis", 32'(misalign), 32'h1);
    chk("lit_jalr_link", 32'(link_addr), 32'h22);
    idle(2);

    op(J, 16'h0, 16'hFF26);
    idle(2);
    resume = 1'b1;
    idle(1);
    chk("lit_resume_in_run", 32'(instr_addr), 32'h30);
    resume = 1'b0;

    op(HALT, 16'h0, 16'h0);
    for (int i = 0; i < 5; i++) op(J, 16'h0, 16'h0040);
    chk("lit_halt_hold", 32'(instr_addr), 32'h30);
    chk("lit_halted", 32'(halted), 32'h1);
    instr_valid = 1'b0;
    stall = 1'b1;
    resume = 1'b1;
    idle(1);
    chk("lit_resume_pc", 32'(instr_addr), 32'h32);
    stall = 1'b0;
    resume = 1'b0;

    op(BNEZ, 16'h0000, 16'h0040);
    op(BLTZ, 16'h8000, 16'h0003);
    chk("lit_bltz_pc", 32'(instr_addr), 32'h38);
    idle(2);
    op(BGEZ, 16'h8000, 16'h0010);
    op(BGEZ, 16'h0005, 16'h0002);
    idle(2);
    op(BNEZ, 16'h0001, 16'hFFFE);
    idle(2);
    chk("lit_bnez_back", 32'(instr_addr), 32'h4A);

    stall = 1'b1;
    op(JAL, 16'h0, 16'h0100);
    stall = 1'b0;

    op(SIIC, 16'h0, 16'h0);
`ifdef PC_EXC_EN
    chk("lit_siic_pc", 32'(instr_addr), 32'h2);
    chk("lit_siic_epc", 32'(epc), 32'h4C);
    idle(2);
    op(RTI, 16'h0, 16'h0);
    chk("lit_rti_pc", 32'(instr_addr), 32'h4C);
    chk("lit_rti_flush", 32'(flush), 32'h1);
    idle(2);
`else
    chk("lit_siic_seq", 32'(instr_addr), 32'h4C);
    idle(2);
    op(RTI, 16'h0, 16'h0);
    chk("lit_rti_seq", 32'(instr_addr), 32'h4E);
`endif

    op(JR, 16'hFFF0, 16'h000A);
    idle(2);
    op(NOP, 16'h0, 16'h0);
    chk("lit_wrap_pc", 32'(instr_addr), 32'h0);

    op(JAL, 16'h0, 16'h0010);
    chk("lit_jal_link", 32'(link_addr), 32'h2);
    stall = 1'b1;
    idle(3);
    chk("lit_stall_pc", 32'(instr_addr), 32'h12);
    chk("lit_stall_flush", 32'(flush), 32'h1);
    stall = 1'b0;
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("lit_rst_flush_pc", 32'(instr_addr), 32'h0);
    chk("lit_rst_flush", 32'(flush), 32'h0);

    op(HALT, 16'h0, 16'h0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("lit_rst_halt", 32'(halted), 32'h0);
    op(NOP, 16'h0, 16'h0);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
